// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for dm_4k with sub-word read-modify-write.
// Optional feature macro MEM_ACCESS_MISALIGN_CHK_EN: reject illegal/misaligned requests with an err pulse.
module mem_access_unit #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_rd,
   input  logic              ex_wr,
   input  logic [1:0]        ex_size,
   input  logic              ex_unsigned,
   input  logic [31:0]       ex_addr,
   input  logic [31:0]       ex_wdata,
   output logic              stall,
   output logic              wb_valid,
   output logic [31:0]       wb_rdata,
   output logic              err,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_wr,
   output logic              dm_rd,
   input  logic [31:0]       dm_dout
);
   typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W+1:0] addr_q, addr_d, addr_in;
   logic [31:0]       wdata_q, wdata_d, merge_q, merge_d, wb_rdata_q, wb_rdata_d;
   logic [1:0]        size_q, size_d, size_in;
   logic              uns_q, uns_d, wr_q, wr_d, wb_valid_q, wb_valid_d, err_q, err_d;
   logic              req, ready, bad, accept, wr_in, sub_st, in_access;
   logic [4:0]        sh;
   logic [31:0]       lane, ld_ext, mask, merged;
   logic              unused_bits;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
   assign bad     = (ex_rd & ex_wr) | (ex_size == 2'b11) | ((ex_size == 2'b01) & ex_addr[0])
                  | ((ex_size == 2'b10) & (ex_addr[1:0] != 2'b00));
   assign size_in = ex_size;
   assign addr_in = ex_addr[ADDR_W+1:0];
`else
   assign bad     = 1'b0;
   assign size_in = ex_size[1] ? 2'b10 : ex_size;
   assign addr_in = {ex_addr[ADDR_W+1:2], size_in[1] ? 2'b00 : {ex_addr[1], ex_addr[0] & ~size_in[0]}};
`endif
   assign wr_in     = ex_wr & ~ex_rd;
   assign req       = ex_valid & (ex_rd | ex_wr);
   assign in_access = state_q == ACCESS;
   assign sub_st    = wr_q & (size_q != 2'b10);
   assign ready     = ~in_access | ~sub_st;
   assign accept    = req & ready & ~bad;
   assign stall     = req & ~ready;
   assign sh        = {addr_q[1:0], 3'b000};
   assign lane      = dm_dout >> sh;
   assign ld_ext    = (size_q == 2'b00) ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                      (size_q == 2'b01) ? {{16{~uns_q & lane[15]}}, lane[15:0]} : dm_dout;
   assign mask      = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
   assign merged    = (merge_q & ~mask) | ((wdata_q << sh) & mask);
   assign dm_addr   = addr_q[ADDR_W+1:2];
   assign dm_din    = (state_q == MERGE) ? merged : wdata_q;
   assign dm_rd     = in_access & (~wr_q | sub_st);
   assign dm_wr     = (state_q == MERGE) | (in_access & wr_q & ~sub_st);
   assign wb_valid  = wb_valid_q;
   assign wb_rdata  = wb_rdata_q;
   assign err       = err_q;
   assign unused_bits = ^{ex_addr[31:ADDR_W+2], lane[31:16]};
   // Next state: capture accepted requests, buffer the old word for sub-word stores, register load results.
   always_comb begin
      state_d    = (in_access & sub_st) ? MERGE : accept ? ACCESS : IDLE;
      addr_d     = accept ? addr_in : addr_q;
      wdata_d    = accept ? ex_wdata : wdata_q;
      size_d     = accept ? size_in : size_q;
      uns_d      = accept ? ex_unsigned : uns_q;
      wr_d       = accept ? wr_in : wr_q;
      merge_d    = (in_access & sub_st) ? dm_dout : merge_q;
      wb_valid_d = in_access & ~wr_q;
      wb_rdata_d = (in_access & ~wr_q) ? ld_ext : wb_rdata_q;
      err_d      = req & ready & bad;
   end
   // State and datapath registers; reset drops any in-flight merge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         wr_q       <= 1'b0;
         merge_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         wr_q       <= wr_d;
         merge_q    <= merge_d;
         wb_valid_q <= wb_valid_d;
         wb_rdata_q <= wb_rdata_d;
         err_q      <= err_d;
      end
   end
endmodule
